// File: rtl/spm_seq.sv
// Operand sequencer and product collector for the serial-parallel multiplier spm.
// Feeds x/y/ld to spm and deserialises its LSB-first product stream into prod.
module spm_seq #(
    parameter int SIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE-1:0]     mc,
    input  logic [SIZE-1:0]     mp,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*SIZE-1:0]   prod,
    output logic [SIZE-1:0]     x_o,
    output logic                y_o,
    output logic                ld_o,
    input  logic                p_i
);

    localparam int CW = $clog2(2*SIZE);
    localparam logic [CW-1:0] LAST = CW'(2*SIZE-1);

    typedef enum logic [1:0] {IDLE, SHIFT, TAIL, DONE} state_t;

    state_t                   state, state_nxt;
    logic [CW-1:0]            cnt;
    logic signed [SIZE-1:0]   mpr;
    logic [2*SIZE-1:0]        acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Outputs depend on registered state only; y_o takes the multiplier LSB,
    // and the arithmetic shift below supplies the sign extension once mp runs out.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        ld_o      = 1'b0;
        y_o       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                ld_o     = 1'b1;
                if (in_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                y_o = mpr[0];
                if (cnt == LAST) state_nxt = TAIL;
            end
            TAIL: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                ld_o      = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_o  <= '0;
            mpr  <= '0;
            cnt  <= '0;
            acc  <= '0;
            prod <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_o <= mc;
                        mpr <= mp;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    mpr <= mpr >>> 1;
                    cnt <= cnt + CW'(1);
                    // spm output lags y by one cycle, so the first slot carries no product bit
                    if (cnt != '0) acc <= {p_i, acc[2*SIZE-1:1]};
                end
                TAIL: prod <= {p_i, acc[2*SIZE-1:1]};
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spm_seq.sv
// Directed and random bench for spm_seq, with a behavioural serial-parallel
// multiplier standing in for spm.
module tb_spm_seq;

    localparam int SIZE = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [SIZE-1:0]     mc = '0;
    logic [SIZE-1:0]     mp = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [2*SIZE-1:0]   prod;
    logic [SIZE-1:0]     x_o;
    logic                y_o;
    logic                ld_o;
    logic                p_i;

    int total = 0;
    int bad = 0;
    int acc_seen = 0;
    int acc_exp = 0;

    spm_seq #(.SIZE(SIZE)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .mc(mc), .mp(mp),
        .out_valid(out_valid), .out_ready(out_ready),
        .prod(prod),
        .x_o(x_o), .y_o(y_o), .ld_o(ld_o), .p_i(p_i)
    );

    always #5 clk = ~clk;

    // spm stand-in: shift-add with one register of output latency
    logic signed [SIZE+1:0] macc;
    logic signed [SIZE+1:0] msum;
    assign msum = macc + (y_o ? $signed({{2{x_o[SIZE-1]}}, x_o}) : $signed({(SIZE+2){1'b0}}));

    always @(posedge clk or posedge rst) begin
        if (rst || ld_o) begin
            macc <= '0;
            p_i  <= 1'b0;
        end else begin
            p_i  <= msum[0];
            macc <= msum >>> 1;
        end
    end

    always @(posedge clk)
        if (!rst && in_valid && in_ready) acc_seen++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic [63:0] e,
                       input int hold, input bit poke, input string tag);
        int n;
        int ldlow;
        bit stable;
        logic [63:0] pv;
        chk({tag, ":in_ready"}, 64'(in_ready), 64'(1));
        out_ready = (hold == 0);
        mc = a; mp = b; in_valid = 1'b1;
        acc_exp++;
        @(posedge clk); #1;
        in_valid = 1'b0; mc = ~a; mp = ~b;
        n = 1; ldlow = 0;
        while (!out_valid && n < 200) begin
            if (!ld_o) ldlow++;
            if (poke) in_valid = (n == 10);
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk({tag, ":latency"}, 64'(n), 64'(66));
        chk({tag, ":ld_low"}, 64'(ldlow), 64'(65));
        chk({tag, ":prod"}, prod, e);
        chk({tag, ":x_o"}, 64'(x_o), 64'(a));
        chk({tag, ":ld_done"}, 64'(ld_o), 64'(1));
        if (hold > 0) begin
            stable = 1'b1;
            pv = prod;
            in_valid = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                if (!out_valid || prod !== pv || in_ready) stable = 1'b0;
            end
            chk({tag, ":hold"}, 64'(stable), 64'(1));
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, ":released"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] rr;

        #22;
        chk("rst:in_ready", 64'(in_ready), 64'(1));
        chk("rst:ld_o", 64'(ld_o), 64'(1));
        chk("rst:out_valid", 64'(out_valid), 64'(0));
        chk("rst:x_o", 64'(x_o), 64'(0));
        chk("rst:y_o", 64'(y_o), 64'(0));
        chk("rst:prod", prod, 64'(0));
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        txn(32'd3, 32'd5, 64'h0000_0000_0000_000F, 0, 1'b0, "3x5");
        txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 0, 1'b0, "m1xm1");
        txn(32'hFFFF_FFFB, 32'd7, 64'hFFFF_FFFF_FFFF_FFDD, 0, 1'b0, "m5x7");
        txn(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 0, 1'b0, "maxxmin");
        txn(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 1'b0, "minxmin");
        txn(32'd12, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFDC, 10, 1'b0, "backpressure");
        txn(32'd9, 32'd11, 64'h0000_0000_0000_0063, 0, 1'b1, "poke");

        // abort mid-operation; prod currently holds 0x63 so its clear is visible
        mc = 32'd3; mp = 32'd5; in_valid = 1'b1;
        acc_exp++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("abort:in_ready", 64'(in_ready), 64'(1));
        chk("abort:ld_o", 64'(ld_o), 64'(1));
        chk("abort:out_valid", 64'(out_valid), 64'(0));
        chk("abort:x_o", 64'(x_o), 64'(0));
        chk("abort:y_o", 64'(y_o), 64'(0));
        chk("abort:prod", prod, 64'(0));
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        txn(32'd3, 32'd5, 64'h0000_0000_0000_000F, 0, 1'b0, "after_abort");

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rr = {{32{ra[31]}}, ra} * {{32{rb[31]}}, rb};
            txn(ra, rb, rr, int'($urandom_range(0, 2)), 1'b0, "rand");
        end

        chk("accept_count", 64'(acc_seen), 64'(acc_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
